nbody_tile_scheduler: RTL and testbench

Sequences an N-body force computation across a fixed PxP systolic force array. For each (I,J) tile pair it drives the i-/j-body read addresses and lane-valid masks, waits out the array pipeline, and signals row-accumulator seeding and commit. It sits between the body memory and the PxP systolic cell array, which is the datapath it controls. It contains no arithmetic on positions, masses or momenta.

---
 rtl/nbody_tile_scheduler.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_nbody_tile_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nbody_tile_scheduler.sv
// ---------------------------------------------------------------------------
// nbody_tile_scheduler
//
// Sequences an N-body force computation over a PxP systolic force array.
// The body set is cut into T = ceil(n/P) tiles per dimension. Tiles are
// visited with I as the outer index and J as the inner index, diagonal tiles
// included. Each tile has three phases:
//   FEED  - P beats, one per lane, carrying the i-/j-body addresses and
//           valid masks. A beat completes only when the body memory is
//           ready.
//   FLUSH - 2P-1 idle cycles so that the array pipeline can drain.
//   (after the last J of a row) COMMIT - the row accumulators are final.
// The block does no arithmetic on positions, masses or momenta.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   start          begin a run (sampled only while idle)
//   n_bodies       body count, latched when start is accepted
//   abort          synchronous return to idle; no commit and no done
//   feed_ready     body memory accepts the current feed beat
//   busy           run in progress (cleared on the done cycle)
//   feed_en        valid feed beat
//   feed_lane      lane index k of the beat
//   feed_i_addr    I*P+k, truncated to AW bits
//   feed_j_addr    J*P+k, truncated to AW bits
//   feed_i_valid   I*P+k < n; the datapath uses mass 0 when low
//   feed_j_valid   J*P+k < n
//   row_first      beat belongs to a J==0 tile; accumulators seed with 0
//   commit         one-cycle pulse; row I accumulators are final
//   commit_i_base  I*P, valid with commit
//   done           one-cycle pulse at the end of the run
//   err            one-cycle pulse: start with n_bodies > MAX_BODIES
//
// Every output is a flop. Its next value is derived from the next-state
// values, so the outputs line up with the state that is being entered.
// ---------------------------------------------------------------------------
module nbody_tile_scheduler #(
  parameter int P          = 2,
  parameter int MAX_BODIES = 64,
  parameter int AW         = $clog2(MAX_BODIES)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [AW:0]                         n_bodies,
  input  logic                                abort,
  input  logic                                feed_ready,
  output logic                                busy,
  output logic                                feed_en,
  output logic [((P > 1) ? $clog2(P) : 1)-1:0] feed_lane,
  output logic [AW-1:0]                       feed_i_addr,
  output logic [AW-1:0]                       feed_j_addr,
  output logic                                feed_i_valid,
  output logic                                feed_j_valid,
  output logic                                row_first,
  output logic                                commit,
  output logic [AW-1:0]                       commit_i_base,
  output logic                                done,
  output logic                                err
);

  localparam int LW = (P > 1) ? $clog2(P) : 1;
  // Tile indices, body counts and address sums share one width. That width
  // is one bit wider than an address, so lanes past n never wrap.
  localparam int CW = AW + 1;
  localparam int FW = $clog2(2 * P);

  localparam logic [LW-1:0] LANE_LAST  = LW'(P - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * P - 2);
  localparam logic [CW-1:0] P_CW       = CW'(P);
  localparam logic [CW-1:0] MAX_N      = CW'(MAX_BODIES);
  localparam logic [CW-1:0] ONE_CW     = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_COMMIT,
    S_DONE
  } state_t;

  // Control state.
  state_t          state_q, state_d;
  logic [LW-1:0]   k_q, k_d;
  logic [CW-1:0]   i_q, i_d;
  logic [CW-1:0]   j_q, j_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [CW-1:0]   n_q, n_d;
  logic [CW-1:0]   t_q, t_d;

  // Registered outputs.
  logic            busy_q, busy_d;
  logic            feed_en_q, feed_en_d;
  logic [LW-1:0]   feed_lane_q, feed_lane_d;
  logic [AW-1:0]   feed_i_addr_q, feed_i_addr_d;
  logic [AW-1:0]   feed_j_addr_q, feed_j_addr_d;
  logic            feed_i_valid_q, feed_i_valid_d;
  logic            feed_j_valid_q, feed_j_valid_d;
  logic            row_first_q, row_first_d;
  logic            commit_q, commit_d;
  logic [AW-1:0]   commit_i_base_q, commit_i_base_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Full-width address arithmetic for the tile that is being entered.
  logic [CW-1:0]   i_base_d, j_base_d;
  logic [CW-1:0]   sum_i_d, sum_j_d;

  // Next-state logic. FEED advances k only on an accepted beat. FLUSH is a
  // fixed-length count that ignores feed_ready. Abort overrides every other
  // transition outside IDLE and clears the tile position.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    fcnt_d  = fcnt_q;
    n_d     = n_q;
    t_d     = t_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_bodies == '0) begin
            state_d = S_DONE;
          end else if (n_bodies > MAX_N) begin
            err_d = 1'b1;
          end else begin
            n_d     = n_bodies;
            t_d     = CW'((int'(n_bodies) + P - 1) / P);
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            fcnt_d  = '0;
            state_d = S_FEED;
          end
        end
      end

      S_FEED: begin
        if (feed_ready) begin
          if (k_q == LANE_LAST) begin
            k_d     = '0;
            fcnt_d  = '0;
            state_d = S_FLUSH;
          end else begin
            k_d = k_q + LW'(1);
          end
        end
      end

      S_FLUSH: begin
        if (fcnt_q == FLUSH_LAST) begin
          fcnt_d = '0;
          if (j_q == t_q - ONE_CW) begin
            state_d = S_COMMIT;
          end else begin
            j_d     = j_q + ONE_CW;
            state_d = S_FEED;
          end
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end

      S_COMMIT: begin
        if (i_q == t_q - ONE_CW) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + ONE_CW;
          j_d     = '0;
          state_d = S_FEED;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      k_d     = '0;
      i_d     = '0;
      j_d     = '0;
      fcnt_d  = '0;
    end
  end

  // Output values for the next cycle. They are derived from the next state,
  // so a beat and its addresses change together on a single edge. A stalled
  // beat recomputes to exactly the same values.
  always_comb begin
    i_base_d = i_d * P_CW;
    j_base_d = j_d * P_CW;
    sum_i_d  = i_base_d + CW'(k_d);
    sum_j_d  = j_base_d + CW'(k_d);

    busy_d          = (state_d == S_FEED) || (state_d == S_FLUSH) ||
                      (state_d == S_COMMIT);
    feed_en_d       = 1'b0;
    feed_lane_d     = '0;
    feed_i_addr_d   = '0;
    feed_j_addr_d   = '0;
    feed_i_valid_d  = 1'b0;
    feed_j_valid_d  = 1'b0;
    row_first_d     = 1'b0;
    commit_d        = 1'b0;
    commit_i_base_d = '0;
    done_d          = (state_d == S_DONE);

    if (state_d == S_FEED) begin
      feed_en_d      = 1'b1;
      feed_lane_d    = k_d;
      feed_i_addr_d  = sum_i_d[AW-1:0];
      feed_j_addr_d  = sum_j_d[AW-1:0];
      // The compare uses the untruncated sum so that padding lanes are masked.
      feed_i_valid_d = (sum_i_d < n_d);
      feed_j_valid_d = (sum_j_d < n_d);
      row_first_d    = (j_d == '0);
    end

    if (state_d == S_COMMIT) begin
      commit_d        = 1'b1;
      commit_i_base_d = i_base_d[AW-1:0];
    end
  end

  // The single state register. Asserting reset clears all outputs at once,
  // so a run cut short by reset never emits commit or done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      k_q             <= '0;
      i_q             <= '0;
      j_q             <= '0;
      fcnt_q          <= '0;
      n_q             <= '0;
      t_q             <= '0;
      busy_q          <= 1'b0;
      feed_en_q       <= 1'b0;
      feed_lane_q     <= '0;
      feed_i_addr_q   <= '0;
      feed_j_addr_q   <= '0;
      feed_i_valid_q  <= 1'b0;
      feed_j_valid_q  <= 1'b0;
      row_first_q     <= 1'b0;
      commit_q        <= 1'b0;
      commit_i_base_q <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      i_q             <= i_d;
      j_q             <= j_d;
      fcnt_q          <= fcnt_d;
      n_q             <= n_d;
      t_q             <= t_d;
      busy_q          <= busy_d;
      feed_en_q       <= feed_en_d;
      feed_lane_q     <= feed_lane_d;
      feed_i_addr_q   <= feed_i_addr_d;
      feed_j_addr_q   <= feed_j_addr_d;
      feed_i_valid_q  <= feed_i_valid_d;
      feed_j_valid_q  <= feed_j_valid_d;
      row_first_q     <= row_first_d;
      commit_q        <= commit_d;
      commit_i_base_q <= commit_i_base_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign busy          = busy_q;
  assign feed_en       = feed_en_q;
  assign feed_lane     = feed_lane_q;
  assign feed_i_addr   = feed_i_addr_q;
  assign feed_j_addr   = feed_j_addr_q;
  assign feed_i_valid  = feed_i_valid_q;
  assign feed_j_valid  = feed_j_valid_q;
  assign row_first     = row_first_q;
  assign commit        = commit_q;
  assign commit_i_base = commit_i_base_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_nbody_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tb_nbody_tile_scheduler
//
// Directed bench for nbody_tile_scheduler with P=2 and MAX_BODIES=64.
// Each table row holds the inputs for one cycle and the full output word
// expected in that same cycle. Row 0 is the cycle in which start is high.
// The reference trace (n=4, no stalls) is written out by hand. The n=3,
// stall and abort traces are hand-edited copies of it.
// ---------------------------------------------------------------------------
module tb_nbody_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] n_bodies;
  logic       abort;
  logic       feed_ready;
  logic       busy;
  logic       feed_en;
  logic [0:0] feed_lane;
  logic [5:0] feed_i_addr;
  logic [5:0] feed_j_addr;
  logic       feed_i_valid;
  logic       feed_j_valid;
  logic       row_first;
  logic       commit;
  logic [5:0] commit_i_base;
  logic       done;
  logic       err;

  // Output word layout:
  // {busy, feed_en, lane, i_addr, j_addr, i_valid, j_valid, row_first,
  //  commit, commit_i_base, done, err}
  typedef struct {
    logic        st;
    logic        ab;
    logic        rdy;
    logic [6:0]  n;
    logic [26:0] exp;
  } vec_t;

  vec_t base[$];
  vec_t tbl[$];

  int checks = 0;
  int passes = 0;

  nbody_tile_scheduler #(.P(2), .MAX_BODIES(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .n_bodies      (n_bodies),
    .abort         (abort),
    .feed_ready    (feed_ready),
    .busy          (busy),
    .feed_en       (feed_en),
    .feed_lane     (feed_lane),
    .feed_i_addr   (feed_i_addr),
    .feed_j_addr   (feed_j_addr),
    .feed_i_valid  (feed_i_valid),
    .feed_j_valid  (feed_j_valid),
    .row_first     (row_first),
    .commit        (commit),
    .commit_i_base (commit_i_base),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic st, logic ab, logic rdy, logic [6:0] n,
                              logic [26:0] e);
    vec_t v;
    v.st  = st;
    v.ab  = ab;
    v.rdy = rdy;
    v.n   = n;
    v.exp = e;
    return v;
  endfunction

  function automatic vec_t r_idle(logic st, logic [6:0] n);
    return mk(st, 1'b0, 1'b1, n, 27'd0);
  endfunction

  function automatic vec_t r_feed(logic lane, logic [5:0] ia, logic [5:0] ja,
                                  logic iv, logic jv, logic rf);
    return mk(1'b0, 1'b0, 1'b1, 7'd0,
              {1'b1, 1'b1, lane, ia, ja, iv, jv, rf, 1'b0, 6'd0, 1'b0, 1'b0});
  endfunction

  function automatic vec_t r_busy();
    return mk(1'b0, 1'b0, 1'b1, 7'd0, {1'b1, 26'd0});
  endfunction

  function automatic vec_t r_commit(logic [5:0] cb);
    return mk(1'b0, 1'b0, 1'b1, 7'd0,
              {1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, cb, 1'b0, 1'b0});
  endfunction

  function automatic vec_t r_done();
    return mk(1'b0, 1'b0, 1'b1, 7'd0, 27'b10);
  endfunction

  function automatic vec_t r_err();
    return mk(1'b0, 1'b0, 1'b1, 7'd0, 27'b1);
  endfunction

  function automatic logic [26:0] actual_word();
    return {busy, feed_en, feed_lane, feed_i_addr, feed_j_addr, feed_i_valid,
            feed_j_valid, row_first, commit, commit_i_base, done, err};
  endfunction

  // Drive one row's inputs on the falling edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    start      = v.st;
    abort      = v.ab;
    feed_ready = v.rdy;
    n_bodies   = v.n;
  endtask

  task automatic checkOutput(input logic [26:0] expv, input string name,
                             input int idx);
    logic [26:0] act;
    act = actual_word();
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s row %0d: got %07h expected %07h",
                  name, idx, act, expv);
  endtask

  task automatic runTable(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i].exp, name, i);
    end
  endtask

  initial begin
    vec_t v;

    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    feed_ready = 1'b1;
    n_bodies   = '0;

    // Reference trace: n=4, T=2, each tile 5 cycles, commit after each row.
    base.push_back(r_idle(1'b1, 7'd4));              // c0  start
    base.push_back(r_feed(1'b0, 6'd0, 6'd0, 1, 1, 1)); // c1  tile (0,0)
    base.push_back(r_feed(1'b1, 6'd1, 6'd1, 1, 1, 1)); // c2
    for (int i = 0; i < 3; i++) base.push_back(r_busy()); // c3-5
    base.push_back(r_feed(1'b0, 6'd0, 6'd2, 1, 1, 0)); // c6  tile (0,1)
    base.push_back(r_feed(1'b1, 6'd1, 6'd3, 1, 1, 0)); // c7
    for (int i = 0; i < 3; i++) base.push_back(r_busy()); // c8-10
    base.push_back(r_commit(6'd0));                    // c11
    base.push_back(r_feed(1'b0, 6'd2, 6'd0, 1, 1, 1)); // c12 tile (1,0)
    base.push_back(r_feed(1'b1, 6'd3, 6'd1, 1, 1, 1)); // c13
    for (int i = 0; i < 3; i++) base.push_back(r_busy()); // c14-16
    base.push_back(r_feed(1'b0, 6'd2, 6'd2, 1, 1, 0)); // c17 tile (1,1)
    base.push_back(r_feed(1'b1, 6'd3, 6'd3, 1, 1, 0)); // c18
    for (int i = 0; i < 3; i++) base.push_back(r_busy()); // c19-21
    base.push_back(r_commit(6'd2));                    // c22
    base.push_back(r_done());                          // c23
    base.push_back(r_idle(1'b0, 7'd0));                // c24

    // Outputs are already zero while reset is held.
    repeat (2) @(negedge clk);
    checkOutput(27'd0, "reset_state", 0);
    rst = 1'b0;

    tbl = base;
    runTable("n4_run");

    // n=3: lane 1 of the I=1 tiles and of the J=1 tiles falls past n.
    tbl = base;
    v = tbl[0]; v.n = 7'd3; tbl[0] = v;
    tbl[7]  = r_feed(1'b1, 6'd1, 6'd3, 1, 0, 0);
    tbl[13] = r_feed(1'b1, 6'd3, 6'd1, 0, 1, 1);
    tbl[18] = r_feed(1'b1, 6'd3, 6'd3, 0, 0, 0);
    runTable("n3_run");

    // Stall of 3 cycles on the lane-1 beat of tile (0,0). The beat is held
    // during c2-4 and completes at c5, so done moves from c23 to c26.
    tbl = base;
    v = base[2]; v.rdy = 1'b0;
    for (int i = 0; i < 3; i++) tbl.insert(2, v);
    runTable("stall_run");

    // n=0 finishes at once without going busy.
    tbl.delete();
    tbl.push_back(r_idle(1'b1, 7'd0));
    tbl.push_back(r_done());
    tbl.push_back(r_idle(1'b0, 7'd0));
    tbl.push_back(r_idle(1'b0, 7'd0));
    runTable("n0_run");

    // n=MAX+1 is rejected with a single err pulse.
    tbl.delete();
    tbl.push_back(r_idle(1'b1, 7'd65));
    tbl.push_back(r_err());
    tbl.push_back(r_idle(1'b0, 7'd0));
    tbl.push_back(r_idle(1'b0, 7'd0));
    runTable("n65_err");

    // n=MAX is accepted; abort it during the first tile.
    tbl.delete();
    tbl.push_back(r_idle(1'b1, 7'd64));
    tbl.push_back(r_feed(1'b0, 6'd0, 6'd0, 1, 1, 1));
    v = r_feed(1'b1, 6'd1, 6'd1, 1, 1, 1); v.ab = 1'b1;
    tbl.push_back(v);
    tbl.push_back(r_idle(1'b0, 7'd0));
    tbl.push_back(r_idle(1'b0, 7'd0));
    runTable("n64_abort");

    // Abort in the FLUSH of tile (0,1) at c9. The outputs stay zero with no
    // commit or done. A fresh start then replays the whole reference trace.
    tbl.delete();
    for (int i = 0; i < 9; i++) tbl.push_back(base[i]);
    v = base[9]; v.ab = 1'b1;
    tbl.push_back(v);
    for (int i = 0; i < 5; i++) tbl.push_back(r_idle(1'b0, 7'd0));
    runTable("flush_abort");
    tbl = base;
    runTable("after_abort");

    // Reset in FEED. The outputs clear without waiting for a clock edge.
    tbl.delete();
    for (int i = 0; i < 7; i++) tbl.push_back(base[i]);
    runTable("pre_rst");
    @(posedge clk);
    #2;
    checkOutput(base[7].exp, "beat_before_rst", 7);
    rst = 1'b1;
    #1;
    checkOutput(27'd0, "rst_async", 0);
    @(negedge clk);
    rst = 1'b0;
    tbl = base;
    runTable("after_rst");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
